onehot_decoder: RTL and testbench
=================================

# onehot_decoder

Sequential one-hot decoder: the receiving end of the priority encoder's index output. Accepts a binary bit index over a valid/ready handshake and drives the matching one-hot vector for a programmable number of cycles, then clears it. It lets an encoded grant or interrupt index be turned back into a per-line strobe for the downstream vector it came from.

## Interface

- OUT_WIDTH, 64, width of the one-hot output vector; ≥ 2, need not be a power of two.
- HOLD, 4, number of cycles the one-hot output stays asserted; ≥ 1.
- IDX_WIDTH (localparam), $clog2(OUT_WIDTH), index width.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  index present on in_idx.
- in_ready  output  1  block can accept an index this cycle.
- in_idx  input  IDX_WIDTH  binary bit position to assert.
- out  output  OUT_WIDTH  registered one-hot vector (all-zero when idle).
- out_valid  output  1  out holds a decoded pulse.
- busy  output  1  high while in HOLD state.
- err  output  1  one-cycle out-of-range flag (see Configuration).

## Operation

- States: IDLE, HOLD. State register, down-counter cnt (width $clog2(HOLD+1)), out, out_valid, err are all registered.
- in_ready = (state == IDLE) && !rst; combinational from the state register only, never from in_valid.
- Transfer occurs on a rising edge with in_valid && in_ready.
- IDLE, transfer, in-range idx: out <= 1 << idx; out_valid <= 1; cnt <= HOLD-1; go to HOLD.
- IDLE, no transfer: out = 0, out_valid = 0, stay.
- HOLD: in_ready = 0; in_valid ignored, and in_idx need not be held stable by the sender.
- HOLD, cnt != 0: cnt <= cnt-1; out unchanged.
- HOLD, cnt == 0: out <= 0; out_valid <= 0; go to IDLE.
- busy = (state == HOLD).
- Exactly one bit of out is set whenever out_valid = 1 and the index was in range.
- Out-of-range idx (idx ≥ OUT_WIDTH, only possible for non-power-of-two OUT_WIDTH): handling per Configuration.

## Timing

- Reset values: out = 0, out_valid = 0, busy = 0, err = 0, state = IDLE, cnt = 0. in_ready = 0 during any cycle with rst = 1, and 1 in the first cycle after rst deasserts.
- Latency: transfer at edge k → out/out_valid visible from edge k through edge k+HOLD (HOLD cycles). Cleared at edge k+HOLD.
- in_ready returns to 1 after edge k+HOLD. Earliest next transfer is edge k+HOLD+1.
- Sustained throughput: one index per HOLD+1 cycles. out is low for at least one cycle between consecutive pulses.
- HOLD = 1: a one-cycle pulse; the counter is loaded with 0 and the block exits HOLD on the next edge.
- rst in mid-HOLD: at that edge, out and out_valid clear, busy drops, and the pending pulse is discarded. A transfer presented in the same cycle as rst is not accepted.

## Configuration

- Macro ONEHOT_DEC_RANGE_CHK_EN.
- Defined: an out-of-range idx is accepted (handshake completes) but not decoded. out and out_valid stay 0, state stays IDLE, and err = 1 for the single cycle after the transfer edge. in_ready stays 1.
- Not defined: err is tied to 0. An out-of-range idx is treated like any other: state goes to HOLD for HOLD cycles with out_valid = 1 and out = 0, because the shift falls off the vector.

## Test plan

- Reset: hold rst for 3 cycles with in_valid = 1 → out = 0, out_valid = 0, in_ready = 0 throughout; after rst falls, in_ready = 1 with nothing accepted.
- Single decode, OUT_WIDTH = 64, HOLD = 4: in_idx = 37 accepted at edge k → out = 1<<37 during edges k..k+3; out = 0 and in_ready = 1 after edge k+4.
- Back-to-back: in_valid held high with idx 0, then 63 → out = 0x1 for 4 cycles, then 1 cycle of zero, then bit 63 for 4 cycles. The second idx is accepted exactly at edge k+5.
- HOLD = 1, idx sweep 0..63 with in_valid held high → each bit is a one-cycle pulse, alternating with one zero cycle; popcount(out) ≤ 1 always.
- Reset mid-pulse: assert rst at cnt = 2 → out = 0 and busy = 0 on the next edge; the following idx = 5 decodes normally.
- OUT_WIDTH = 48, idx = 50: with ONEHOT_DEC_RANGE_CHK_EN → one-cycle err = 1, out_valid = 0, in_ready stays 1. Without it → err = 0, out_valid = 1 for HOLD cycles with out = 0.

Source files
------------

// File: rtl/onehot_decoder.sv
// onehot_decoder: sequential binary-index to one-hot decoder.
// Accepts an index over a valid/ready handshake and holds the matching
// one-hot vector on out for HOLD cycles, then clears it for at least one
// cycle before the next index can be taken.
// Optional feature macro: ONEHOT_DEC_RANGE_CHK_EN (when defined, an
// out-of-range index is consumed without decoding and raises err for one cycle).
module onehot_decoder #(
  parameter int OUT_WIDTH = 64,
  parameter int HOLD      = 4,
  localparam int IDX_WIDTH = $clog2(OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_WIDTH-1:0] in_idx,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 err
);

  localparam int CNT_WIDTH = $clog2(HOLD + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [OUT_WIDTH-1:0]   out_reg, out_next;
  logic                   out_valid_reg, out_valid_next;
  logic [OUT_WIDTH-1:0]   dec;
  logic                   xfer;

  // Per-line compare: an index beyond the vector matches no line, so the
  // decode naturally yields all-zero for out-of-range values.
  generate
    for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_dec
      assign dec[gi] = (in_idx == IDX_WIDTH'(gi));
    end
  endgenerate

  // Ready depends only on the state register and reset, never on in_valid.
  assign in_ready  = (state_reg == S_IDLE) && !rst;
  assign xfer      = in_valid && in_ready;
  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg == S_HOLD);

`ifdef ONEHOT_DEC_RANGE_CHK_EN
  logic in_range;
  logic err_reg, err_next;

  assign in_range = |dec;
  assign err      = err_reg;
`else
  assign err = 1'b0;
`endif

  // Next-state, counter and output-vector logic.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
`ifdef ONEHOT_DEC_RANGE_CHK_EN
    err_next       = 1'b0;
`endif
    unique case (state_reg)
      S_IDLE: begin
        out_next       = '0;
        out_valid_next = 1'b0;
        if (xfer) begin
`ifdef ONEHOT_DEC_RANGE_CHK_EN
          if (!in_range) begin
            // Consume the index without decoding; stay idle.
            err_next = 1'b1;
          end else begin
            out_next       = dec;
            out_valid_next = 1'b1;
            cnt_next       = CNT_WIDTH'(HOLD - 1);
            state_next     = S_HOLD;
          end
`else
          out_next       = dec;
          out_valid_next = 1'b1;
          cnt_next       = CNT_WIDTH'(HOLD - 1);
          state_next     = S_HOLD;
`endif
        end
      end
      S_HOLD: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_WIDTH'(1);
        end else begin
          out_next       = '0;
          out_valid_next = 1'b0;
          state_next     = S_IDLE;
        end
      end
      default: begin
        out_next       = '0;
        out_valid_next = 1'b0;
        state_next     = S_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset discards any pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

`ifdef ONEHOT_DEC_RANGE_CHK_EN
  // One-cycle out-of-range flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end
`endif

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed testbench for onehot_decoder: three instances cover the default
// 64-wide HOLD=4 build, a HOLD=1 build and a 48-wide (non power of two) build.
module tb_onehot_decoder;

  logic clk;
  logic rst;

  // 64 wide, HOLD = 4
  logic        in_valid, in_ready, out_valid, busy, err;
  logic [5:0]  in_idx;
  logic [63:0] out;

  // 64 wide, HOLD = 1
  logic        in_valid1, in_ready1, out_valid1, busy1, err1;
  logic [5:0]  in_idx1;
  logic [63:0] out1;

  // 48 wide, HOLD = 4
  logic        in_valid48, in_ready48, out_valid48, busy48, err48;
  logic [5:0]  in_idx48;
  logic [47:0] out48;

  int compared;
  int mismatched;

  onehot_decoder #(.OUT_WIDTH(64), .HOLD(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .out(out), .out_valid(out_valid), .busy(busy), .err(err)
  );

  onehot_decoder #(.OUT_WIDTH(64), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_idx(in_idx1), .out(out1), .out_valid(out_valid1), .busy(busy1), .err(err1)
  );

  onehot_decoder #(.OUT_WIDTH(48), .HOLD(4)) dut48 (
    .clk(clk), .rst(rst), .in_valid(in_valid48), .in_ready(in_ready48),
    .in_idx(in_idx48), .out(out48), .out_valid(out_valid48), .busy(busy48), .err(err48)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_idx = 6'd37;
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if (out !== 64'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_c%0d: out=%h ov=%b rdy=%b busy=%b err=%b required 0/0/0/0/0",
                 c, out, out_valid, in_ready, busy, err);
      end
      $display("reset cycle %0d: out=%h ov=%b rdy=%b", c, out, out_valid, in_ready);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1 || in_ready48 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: rdy=%b/%b/%b required 1/1/1", in_ready, in_ready1, in_ready48);
    end
    tick();
    compared++;
    if (out_valid !== 1'b0 || out !== 64'd0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_nothing_accepted: ov=%b out=%h busy=%b required 0/0/0", out_valid, out, busy);
    end
    $display("reset released: rdy=%b ov=%b", in_ready, out_valid);
  endtask

  task automatic test_single_decode();
    logic [63:0] exp;
    exp = 64'd1 << 37;
    in_valid = 1'b1; in_idx = 6'd37;
    tick();                       // edge k
    in_valid = 1'b0; in_idx = 6'd0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      compared++;
      if (out !== exp || out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL single_hold_c%0d: out=%h ov=%b busy=%b rdy=%b required %h/1/1/0",
                 c, out, out_valid, busy, in_ready, exp);
      end
      $display("single idx=37 cycle %0d: out=%h ov=%b", c, out, out_valid);
    end
    tick();                       // edge k+4
    compared++;
    if (out !== 64'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_clear: out=%h ov=%b rdy=%b busy=%b required 0/0/1/0", out, out_valid, in_ready, busy);
    end
    $display("single idx=37 cleared: out=%h rdy=%b", out, in_ready);
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    logic [63:0] b63;
    b63 = 64'd1 << 63;
    in_valid = 1'b1; in_idx = 6'd0;
    tick();                       // edge k
    in_idx = 6'd63;               // changes while busy; must be ignored until ready
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      if (c == 5) in_valid = 1'b0;
      if (c < 4)      exp = 64'd1;
      else if (c == 4) exp = 64'd0;
      else if (c < 9)  exp = b63;
      else             exp = 64'd0;
      compared++;
      if (out !== exp || out_valid !== (exp != 64'd0)) begin
        mismatched++;
        $display("FAIL b2b_c%0d: out=%h ov=%b required %h/%b", c, out, out_valid, exp, (exp != 64'd0));
      end
      if (c == 4) begin
        compared++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
          mismatched++;
          $display("FAIL b2b_gap_ready: rdy=%b busy=%b required 1/0", in_ready, busy);
        end
      end
      $display("b2b cycle %0d: out=%h ov=%b rdy=%b", c, out, out_valid, in_ready);
    end
  endtask

  task automatic test_hold1_sweep();
    logic [63:0] exp;
    in_valid1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_idx1 = 6'(i);
      tick();
      exp = 64'd1 << i;
      in_idx1 = 6'((i + 1) % 64);
      compared++;
      if (out1 !== exp || out_valid1 !== 1'b1 || $countones(out1) > 1) begin
        mismatched++;
        $display("FAIL hold1_pulse_%0d: out=%h ov=%b required %h/1", i, out1, out_valid1, exp);
      end
      tick();
      compared++;
      if (out1 !== 64'd0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
        mismatched++;
        $display("FAIL hold1_gap_%0d: out=%h ov=%b rdy=%b required 0/0/1", i, out1, out_valid1, in_ready1);
      end
      $display("hold1 idx=%0d pulse then gap ok-check done", i);
    end
    in_valid1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp;
    exp = 64'd1 << 5;
    in_valid = 1'b1; in_idx = 6'd9;
    tick();                       // edge k, cnt=3
    in_valid = 1'b0;
    tick();                       // edge k+1, cnt=2
    compared++;
    if (busy !== 1'b1 || out !== (64'd1 << 9)) begin
      mismatched++;
      $display("FAIL rstmid_pre: busy=%b out=%h required 1/%h", busy, out, 64'd1 << 9);
    end
    rst = 1'b1; in_valid = 1'b1; in_idx = 6'd5;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_ready_in_rst: rdy=%b required 0", in_ready);
    end
    tick();                       // reset edge, transfer must not be taken
    compared++;
    if (out !== 64'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_clear: out=%h ov=%b busy=%b required 0/0/0", out, out_valid, busy);
    end
    rst = 1'b0;
    tick();                       // idx 5 accepted
    in_valid = 1'b0;
    compared++;
    if (out !== exp || out_valid !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_redecode: out=%h ov=%b busy=%b required %h/1/1", out, out_valid, busy, exp);
    end
    for (int c = 0; c < 4; c++) tick();
    compared++;
    if (out !== 64'd0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_final_clear: out=%h rdy=%b required 0/1", out, in_ready);
    end
    $display("reset mid-pulse then idx=5: out now %h rdy=%b", out, in_ready);
  endtask

  task automatic test_range();
    logic [47:0] exp;
    exp = 48'd1 << 47;
    // Top in-range line of the 48-wide build
    in_valid48 = 1'b1; in_idx48 = 6'd47;
    tick();
    in_valid48 = 1'b0;
    compared++;
    if (out48 !== exp || out_valid48 !== 1'b1 || err48 !== 1'b0) begin
      mismatched++;
      $display("FAIL range_idx47: out=%h ov=%b err=%b required %h/1/0", out48, out_valid48, err48, exp);
    end
    for (int c = 0; c < 4; c++) tick();
    compared++;
    if (out48 !== 48'd0 || in_ready48 !== 1'b1) begin
      mismatched++;
      $display("FAIL range_idx47_clear: out=%h rdy=%b required 0/1", out48, in_ready48);
    end
    $display("w48 idx=47 decoded and cleared");
    // Out-of-range index 50
    in_valid48 = 1'b1; in_idx48 = 6'd50;
    tick();
    in_valid48 = 1'b0;
`ifdef ONEHOT_DEC_RANGE_CHK_EN
    compared++;
    if (err48 !== 1'b1 || out_valid48 !== 1'b0 || out48 !== 48'd0 || busy48 !== 1'b0 || in_ready48 !== 1'b1) begin
      mismatched++;
      $display("FAIL range_oor_chk: err=%b ov=%b out=%h busy=%b rdy=%b required 1/0/0/0/1",
               err48, out_valid48, out48, busy48, in_ready48);
    end
    tick();
    compared++;
    if (err48 !== 1'b0 || out_valid48 !== 1'b0) begin
      mismatched++;
      $display("FAIL range_oor_err_oneshot: err=%b ov=%b required 0/0", err48, out_valid48);
    end
    $display("w48 idx=50 with range check: err pulse");
`else
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      compared++;
      if (out_valid48 !== 1'b1 || out48 !== 48'd0 || busy48 !== 1'b1 || err48 !== 1'b0) begin
        mismatched++;
        $display("FAIL range_oor_nochk_c%0d: ov=%b out=%h busy=%b err=%b required 1/0/1/0",
                 c, out_valid48, out48, busy48, err48);
      end
    end
    tick();
    compared++;
    if (out_valid48 !== 1'b0 || busy48 !== 1'b0 || in_ready48 !== 1'b1) begin
      mismatched++;
      $display("FAIL range_oor_nochk_clear: ov=%b busy=%b rdy=%b required 0/0/1", out_valid48, busy48, in_ready48);
    end
    $display("w48 idx=50 without range check: zero pulse for HOLD cycles");
`endif
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1;
    in_valid = 1'b0;   in_idx = '0;
    in_valid1 = 1'b0;  in_idx1 = '0;
    in_valid48 = 1'b0; in_idx48 = '0;
    test_reset();
    test_single_decode();
    test_back_to_back();
    test_hold1_sweep();
    test_reset_mid();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
